// File: rtl/keypad_decoder_pkg.sv
// Shared constants, types and the note-divider table for the keypad decoder.
// Divider values are 10 MHz clock cycles per tone period at octave 0.
package keypad_decoder_pkg;

   localparam int NUM_KEYS  = 13;
   localparam int KEYPAD_W  = 17;
   localparam int DIV_W     = 18;

   localparam int KP_OCT_UP = 16;
   localparam int KP_OCT_DN = 15;
   localparam int KP_MODE   = 14;
   localparam int KP_GOOF   = 13;

   typedef enum logic [1:0] {
      MODE_0 = 2'd0,
      MODE_1 = 2'd1,
      MODE_2 = 2'd2
   } mode_t;

   function automatic logic [DIV_W-1:0] note_div(input logic [3:0] idx);
      case (idx)
         4'd0:    note_div = 18'd76445;
         4'd1:    note_div = 18'd72154;
         4'd2:    note_div = 18'd68106;
         4'd3:    note_div = 18'd64284;
         4'd4:    note_div = 18'd60675;
         4'd5:    note_div = 18'd57270;
         4'd6:    note_div = 18'd54054;
         4'd7:    note_div = 18'd51020;
         4'd8:    note_div = 18'd48157;
         4'd9:    note_div = 18'd45455;
         4'd10:   note_div = 18'd42903;
         4'd11:   note_div = 18'd40495;
         4'd12:   note_div = 18'd38223;
         default: note_div = 18'd0;
      endcase
   endfunction

   function automatic mode_t mode_step(input mode_t m);
      case (m)
         MODE_0:  mode_step = MODE_1;
         MODE_1:  mode_step = MODE_2;
         MODE_2:  mode_step = MODE_0;
         default: mode_step = MODE_0;
      endcase
   endfunction

endpackage

// File: rtl/keypad_decoder_debouncer.sv
// Two-flop synchroniser, sampling prescaler and two-sample agreement debouncer.
// A bit only moves when two consecutive tick samples agree.
module keypad_debouncer #(
   parameter int WIDTH           = 17,
   parameter int DEBOUNCE_CYCLES = 10000
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] deb_o,
   output logic [WIDTH-1:0] press_o
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] samp_cur_q, samp_cur_d, samp_prev_q, samp_prev_d;
   logic [WIDTH-1:0] deb_q, deb_d, deb_dly_q;
   logic [WIDTH-1:0] stable_s;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Prescaler, sample shift and debounced-vector next state
   always_comb begin
      tick_d      = (cnt_q == CNT_LAST);
      cnt_d       = cnt_q;
      samp_cur_d  = samp_cur_q;
      samp_prev_d = samp_prev_q;
      if (tick_d) begin
         cnt_d       = {CNT_W{1'b0}};
         samp_prev_d = samp_cur_q;
         samp_cur_d  = sync2_q;
      end else begin
         cnt_d       = cnt_q + CNT_W'(1);
      end
      stable_s = ~(samp_cur_q ^ samp_prev_q);
      deb_d    = deb_q;
      if (tick_q) begin
         deb_d = (samp_cur_q & stable_s) | (deb_q & ~stable_s);
      end else begin
         deb_d = deb_q;
      end
   end

   // Debouncer state registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1_q     <= {WIDTH{1'b0}};
         sync2_q     <= {WIDTH{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         tick_q      <= 1'b0;
         samp_cur_q  <= {WIDTH{1'b0}};
         samp_prev_q <= {WIDTH{1'b0}};
         deb_q       <= {WIDTH{1'b0}};
         deb_dly_q   <= {WIDTH{1'b0}};
      end else begin
         sync1_q     <= din_i;
         sync2_q     <= sync1_q;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         samp_cur_q  <= samp_cur_d;
         samp_prev_q <= samp_prev_d;
         deb_q       <= deb_d;
         deb_dly_q   <= deb_q;
      end
   end

   assign deb_o   = deb_q;
   assign press_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/keypad_decoder.sv
// Keypad front end for the tone generator: octave/mode tracking, lowest-key
// priority select and a registered period divider with change strobe.
module keypad_decoder
   import keypad_decoder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10000,
   parameter int OCT_MAX         = 4,
   parameter int OCT_DEFAULT     = 1
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [KEYPAD_W-1:0] keypad,
   output logic [DIV_W-1:0]  divider,
   output logic              strobe,
   output logic [2:0]        octave,
   output logic [1:0]        mode,
   output logic              goof
);
   localparam logic [2:0] OCT_MAX_C = 3'(OCT_MAX);
   localparam logic [2:0] OCT_DEF_C = 3'(OCT_DEFAULT);

   logic [KEYPAD_W-1:0] deb_s, press_s;
   logic [DIV_W-1:0]    divider_q, divider_d;
   logic                strobe_q, strobe_d;
   logic [2:0]          octave_q, octave_d;
   mode_t               mode_q, mode_d;
   logic                goof_q, goof_d;
   logic                hit_s;
   logic [3:0]          idx_s;

   keypad_debouncer #(
      .WIDTH           (KEYPAD_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk     (clk),
      .nrst    (nrst),
      .din_i   (keypad),
      .deb_o   (deb_s),
      .press_o (press_s)
   );

   // Octave/mode updates, priority encoder and divider next state
   always_comb begin
      octave_d = octave_q;
      if (press_s[KP_OCT_UP] && !press_s[KP_OCT_DN]) begin
         octave_d = (octave_q != OCT_MAX_C) ? octave_q + 3'd1 : octave_q;
      end else if (press_s[KP_OCT_DN] && !press_s[KP_OCT_UP]) begin
         octave_d = (octave_q != 3'd0) ? octave_q - 3'd1 : octave_q;
      end else begin
         octave_d = octave_q;
      end

      mode_d = mode_q;
      if (press_s[KP_MODE]) begin
         mode_d = mode_step(mode_q);
      end else begin
         mode_d = mode_q;
      end

      goof_d = deb_s[KP_GOOF];

      // Scan downwards so the lowest pressed key is the last one to write idx
      hit_s = 1'b0;
      idx_s = 4'd0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (deb_s[i]) begin
            hit_s = 1'b1;
            idx_s = 4'(i);
         end else begin
            hit_s = hit_s;
            idx_s = idx_s;
         end
      end

      divider_d = {DIV_W{1'b0}};
      if (hit_s) begin
         divider_d = note_div(idx_s) >> octave_q;
      end else begin
         divider_d = {DIV_W{1'b0}};
      end
      strobe_d = (divider_d != divider_q);
   end

   // Output and control-state registers
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         divider_q <= {DIV_W{1'b0}};
         strobe_q  <= 1'b0;
         octave_q  <= OCT_DEF_C;
         mode_q    <= MODE_0;
         goof_q    <= 1'b0;
      end else begin
         divider_q <= divider_d;
         strobe_q  <= strobe_d;
         octave_q  <= octave_d;
         mode_q    <= mode_d;
         goof_q    <= goof_d;
      end
   end

   assign divider = divider_q;
   assign strobe  = strobe_q;
   assign octave  = octave_q;
   assign mode    = mode_q;
   assign goof    = goof_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed and randomized bench for keypad_decoder with a key-level reference
// model: expected divider/octave/mode come from the note table and press rules.
module tb_keypad_decoder;
   localparam int SETTLE  = 30;
   localparam int OCT_MAX = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic [16:0] keypad = 17'd0;
   logic [17:0] divider;
   logic        strobe;
   logic [2:0]  octave;
   logic [1:0]  mode;
   logic        goof;

   int vectors = 0;
   int miscompares = 0;

   int note_tab [13] = '{76445, 72154, 68106, 64284, 60675, 57270, 54054,
                         51020, 48157, 45455, 42903, 40495, 38223};

   logic [16:0] m_kp;
   int          m_oct, m_mode, m_div;

   keypad_decoder #(.DEBOUNCE_CYCLES(4), .OCT_MAX(4), .OCT_DEFAULT(1)) dut (
      .clk(clk), .nrst(nrst), .keypad(keypad), .divider(divider),
      .strobe(strobe), .octave(octave), .mode(mode), .goof(goof)
   );

   always #50 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int tone(input logic [12:0] keys, input int oct);
      for (int i = 0; i < 13; i++)
         if (keys[i]) return note_tab[i] >> oct;
      return 0;
   endfunction

   task automatic model_reset();
      m_kp = 17'd0; m_oct = 1; m_mode = 0; m_div = 0;
   endtask

   // Let the new keypad value settle and compare against the model
   task automatic settle(input logic [16:0] nk, input bit chk_lat, input string tag);
      int v0, v1, v2, noct, nmode, exp_str, n_str, first;
      bit up, dn;
      v0 = m_div;
      up = nk[16] & ~m_kp[16];
      dn = nk[15] & ~m_kp[15];
      noct = m_oct;
      if (up && !dn) noct = (m_oct < OCT_MAX) ? m_oct + 1 : m_oct;
      else if (dn && !up) noct = (m_oct > 0) ? m_oct - 1 : 0;
      nmode = (nk[14] & ~m_kp[14]) ? (m_mode + 1) % 3 : m_mode;
      v1 = tone(nk[12:0], m_oct);
      v2 = tone(nk[12:0], noct);
      exp_str = int'(v1 != v0) + int'(v2 != v1);
      n_str = 0; first = 0;
      for (int k = 1; k <= SETTLE; k++) begin
         @(negedge clk);
         if (strobe === 1'b1) begin
            n_str++;
            if (first == 0) first = k;
         end
      end
      chk({tag, ".divider"}, 32'(divider), 32'(v2));
      chk({tag, ".strobes"}, 32'(n_str), 32'(exp_str));
      chk({tag, ".octave"}, 32'(octave), 32'(noct));
      chk({tag, ".mode"}, 32'(mode), 32'(nmode));
      chk({tag, ".goof"}, 32'(goof), 32'(nk[13]));
      if (chk_lat && exp_str > 0)
         chk({tag, ".latency_ok"}, 32'(first >= 8 && first <= 14), 32'd1);
      m_kp = nk; m_oct = noct; m_mode = nmode; m_div = v2;
   endtask

   task automatic apply(input logic [16:0] nk, input string tag);
      @(negedge clk);
      keypad = nk;
      settle(nk, 1'b1, tag);
   endtask

   task automatic reset_pulse(input string tag);
      @(negedge clk);
      #20 nrst = 1'b0;
      #1;
      chk({tag, ".rst_divider"}, 32'(divider), 32'd0);
      chk({tag, ".rst_strobe"}, 32'(strobe), 32'd0);
      chk({tag, ".rst_octave"}, 32'(octave), 32'd1);
      chk({tag, ".rst_mode"}, 32'(mode), 32'd0);
      chk({tag, ".rst_goof"}, 32'(goof), 32'd0);
      repeat (3) @(negedge clk);
      model_reset();
      nrst = 1'b1;
      settle(keypad, 1'b0, {tag, ".release"});
   endtask

   initial begin
      logic [16:0] nk;
      int r;
      model_reset();
      keypad = 17'h1FFFF;
      #20;
      reset_pulse("rst_all_ones");
      apply(17'd0, "all_release");

      apply(17'd1 << 9, "key9");
      apply(17'd0, "key9_rel");
      apply((17'd1 << 3) | (17'd1 << 7), "keys3_7");
      apply(17'd1 << 7, "drop3");
      apply(17'd0, "rel7");

      for (int i = 0; i < 6; i++) begin
         apply(17'd1 | (17'd1 << 16), "oct_up_press");
         apply(17'd1, "oct_up_rel");
      end
      chk("oct_sat_divider", 32'(divider), 32'd4777);
      apply(17'd1 | (17'd3 << 15), "both_oct");
      apply(17'd1, "both_oct_rel");

      for (int i = 0; i < 4; i++) begin
         apply(17'd1 | (17'd1 << 14), "mode_press");
         apply(17'd1, "mode_rel");
      end

      apply(17'd0, "pre_glitch");
      @(negedge clk); keypad = 17'd1;
      @(negedge clk);
      @(negedge clk); keypad = 17'd0;
      settle(17'd0, 1'b0, "glitch");

      apply(17'd1 << 15, "oct_dn");
      apply(17'd0, "oct_dn_rel");
      apply(17'd1 << 5, "key5_oct3");
      chk("pre_rst_octave", 32'(octave), 32'd3);
      reset_pulse("rst_mid_press");

      for (int s = 0; s < 40; s++) begin
         nk = m_kp;
         r = $urandom_range(0, 3);
         case (r)
            0: nk[12:0] = 13'd0;
            1: nk[12:0] = 13'd1 << $urandom_range(0, 12);
            2: nk[12:0] = 13'($urandom);
            default: nk[12:0] = nk[12:0];
         endcase
         if ($urandom_range(0, 1) == 1) nk[16:13] = 4'($urandom);
         apply(nk, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
